leb128_stream_decoder: RTL
==========================

# leb128_stream_decoder

Byte-serial LEB128 decoder for the WASM front-end. It accepts one encoded byte per cycle over a valid/ready handshake and accumulates an unsigned or signed integer of parametrised width (i32/i64 immediates, indices, section sizes). Each result is presented with its byte count and error flags on a registered valid/ready output. The block checks encoding length and the unused bits of the final byte as the WASM binary format requires.

## Interface
- OUT_W, 32: result width; 32 or 64 only.
- MAX_BYTES, ceil(OUT_W/7): derived, not overridable (5 for 32, 10 for 64).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- is_signed  in  1  mode for the value being decoded; sampled only on its first byte.
- flush  in  1  synchronous abort; discards the partial value and any held result.
- in_byte  in  8  encoded byte; bit 7 is the continuation bit.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  byte is accepted when in_valid & in_ready.
- out_value  out  OUT_W  decoded value; 0 when either error flag is set.
- out_cnt  out  4  bytes consumed for this result (1..MAX_BYTES).
- out_err_long  out  1  continuation bit still set on byte MAX_BYTES.
- out_err_ovf  out  1  unused bits of the final byte are illegal.
- out_valid  out  1  result held until out_ready.
- out_ready  in  1  consumer accepts the result.

## Operation
- States:
  - IDLE: shift = 0, count = 0.
  - ACCUM: partial value in progress.
  - HOLD: result presented on the output.
- On each accepted byte:
  - acc |= in_byte[6:0] << 7·count; count++.
  - On the first byte, latch is_signed.
- The byte is final if bit 7 = 0, or if count reaches MAX_BYTES.
- Final-byte rules for byte index MAX_BYTES-1, where U = OUT_W − 7·(MAX_BYTES−1) (4 for 32, 1 for 64):
  - Unsigned: bits [6:U] must be 0, else out_err_ovf.
  - Signed: bits [6:U−1] must all be equal, else out_err_ovf.
  - Bit 7 set on this byte: out_err_long. out_err_ovf is not evaluated.
- Signed, ended early (7·cnt < OUT_W): sign-extend from bit 7·cnt−1.
- Transitions:
  - IDLE/ACCUM → ACCUM on a non-final byte.
  - IDLE/ACCUM → HOLD on a final byte or error.
  - HOLD → IDLE on out_ready with no byte accepted.
  - HOLD → ACCUM or HOLD on out_ready with a byte accepted the same cycle.
- After out_err_long the block restarts at IDLE. Any trailing continuation bytes are decoded as a new value; the parser must flush.
- flush: in IDLE/ACCUM/HOLD → IDLE; out_valid drops next cycle; the byte presented that cycle is not accepted.
- Widths:
  - Accumulator is 7·MAX_BYTES bits, truncated to OUT_W.
  - count is 4 bits and never exceeds MAX_BYTES.

## Timing
- Reset values: out_value = 0, out_cnt = 0, out_err_long = 0, out_err_ovf = 0, out_valid = 0, in_ready = 1, state IDLE.
- in_ready = (state != HOLD) | out_ready, combinational from out_ready. This is the only combinational in→out path.
- Latency: final byte accepted at edge N → out_valid = 1 after edge N (visible in cycle N+1).
- Throughput: one-byte values sustain one result per cycle while out_ready = 1.
- out_value, out_cnt and the error flags are stable while out_valid & !out_ready.
- If out_ready and a new final byte coincide in HOLD, out_valid stays 1 and the outputs update to the new result.
- in_valid may drop between bytes of one value; the partial value is retained indefinitely.
- rst mid-value clears all state asynchronously; there is no partial output.

## Structure
- Shared package leb128_pkg holds:
  - the leb128_max_bytes(width) function;
  - LEB128_CONT_BIT = 7;
  - the state enum type (IDLE/ACCUM/HOLD);
  - the error-flag struct, shared with a future encoder.
- One sub-module, leb128_last_byte_check: combinational (byte, is_signed, OUT_W) → ovf. Verify it exhaustively in isolation.

## Test plan
- OUT_W=32, unsigned, bytes E5 8E 26 → out_value 0x00098765 (624485), cnt 3, no errors.
- OUT_W=32, signed, bytes C0 BB 78 → 0xFFFE1DC0 (−123456), cnt 3. Signed byte 7F → 0xFFFFFFFF, cnt 1.
- OUT_W=32, unsigned, FF FF FF FF 0F → 0xFFFFFFFF, cnt 5.
  - Last byte 1F instead → out_err_ovf, value 0.
  - Signed FF FF FF FF 7F → −1, legal. Signed …FF 4F → out_err_ovf.
- OUT_W=64, unsigned, 80×9 then 80 → out_err_long, cnt 10. Ten-byte encoding FF×9 01 → 0xFFFF_FFFF_FFFF_FFFF.
- Back-to-back single bytes 01 02 03 with out_ready = 1 every cycle → three results on consecutive cycles.
  - Hold out_ready = 0 for 3 cycles on the second result → in_ready = 0, outputs stable, no byte lost.
- Mid-value sequences:
  - Assert rst after 2 bytes of a 3-byte value → all outputs return to reset values; next byte 05 → 5, cnt 1.
  - flush mid-value → same result.

Source files
------------

// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions: byte-count helper, continuation bit, decoder states and error flags.
package leb128_pkg;

  localparam int unsigned LEB128_CONT_BIT = 7;

  // Bytes needed to carry a value of the given width, 7 payload bits per byte.
  function automatic int unsigned leb128_max_bytes(input int unsigned width);
    return (width + 6) / 7;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } leb128_state_e;

  typedef struct packed {
    logic err_long;
    logic err_ovf;
  } leb128_err_t;

endpackage

// File: rtl/leb128_last_byte_check.sv
// Legality of the unused payload bits in the last permitted byte of an encoding.
module leb128_last_byte_check
  import leb128_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic [6:0] payload,
  input  logic       is_signed,
  output logic       ovf
);

  localparam int unsigned MAX_BYTES = leb128_max_bytes(OUT_W);
  // Payload bits of the last byte that still land inside the result.
  localparam int unsigned USED = OUT_W - 7 * (MAX_BYTES - 1);

  // Unsigned: everything above USED must be 0. Signed: the top used bit and all above must agree.
  localparam logic [6:0] UNS_MASK = 7'h7f << USED;
  localparam logic [6:0] SGN_MASK = 7'h7f << (USED - 1);

  logic [6:0] sgn_bits;

  always_comb begin
    sgn_bits = payload & SGN_MASK;
    if (is_signed) begin
      ovf = (sgn_bits != 7'h00) && (sgn_bits != SGN_MASK);
    end else begin
      ovf = |(payload & UNS_MASK);
    end
  end

endmodule

// File: rtl/leb128_stream_decoder.sv
// Byte-serial LEB128 decoder: accumulates one byte per handshake, presents a held result.
module leb128_stream_decoder
  import leb128_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_value,
  output logic [3:0]       out_cnt,
  output logic             out_err_long,
  output logic             out_err_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned MAX_BYTES = leb128_max_bytes(OUT_W);
  localparam int unsigned ACC_W     = 7 * MAX_BYTES;
  localparam int          OW        = int'(OUT_W);

  leb128_state_e    state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic [3:0]       res_cnt_q, res_cnt_d;
  leb128_err_t      err_q, err_d;

  logic                    accept;
  logic                    cur_signed;
  logic                    last_idx;
  logic                    cont;
  logic                    chk_ovf;
  logic [ACC_W-1:0]        acc_new;
  logic [3:0]              cnt_new;
  logic [OUT_W-1:0]        trunc;
  logic signed [OUT_W-1:0] shifted;
  logic [OUT_W-1:0]        ext_val;
  int                      ext_bits;
  leb128_err_t             err_new;

  assign in_ready     = (state_q != StHold) | out_ready;
  assign accept       = in_valid & in_ready & ~flush;
  assign out_valid    = (state_q == StHold);
  assign out_value    = value_q;
  assign out_cnt      = res_cnt_q;
  assign out_err_long = err_q.err_long;
  assign out_err_ovf  = err_q.err_ovf;

  // A zero count means this is the first byte of a value, including one accepted while in HOLD.
  assign cur_signed = (cnt_q == 4'd0) ? is_signed : signed_q;
  assign last_idx   = (cnt_q == 4'(MAX_BYTES - 1));
  assign cont       = in_byte[LEB128_CONT_BIT];

  leb128_last_byte_check #(
    .OUT_W(OUT_W)
  ) u_last_byte_check (
    .payload  (in_byte[6:0]),
    .is_signed(cur_signed),
    .ovf      (chk_ovf)
  );

  always_comb begin
    acc_new          = acc_q | (ACC_W'(in_byte[6:0]) << (7 * int'(cnt_q)));
    cnt_new          = cnt_q + 4'd1;
    trunc            = acc_new[OUT_W-1:0];
    ext_bits         = 7 * int'(cnt_new);
    shifted          = '0;
    ext_val          = trunc;
    err_new.err_long = last_idx & cont;
    err_new.err_ovf  = last_idx & ~cont & chk_ovf;
    // Signed values that end before filling OUT_W extend from their top payload bit.
    if (cur_signed && (ext_bits < OW)) begin
      shifted = trunc << (OW - ext_bits);
      ext_val = shifted >>> (OW - ext_bits);
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    value_d   = value_q;
    res_cnt_d = res_cnt_q;
    err_d     = err_q;
    if (flush) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = 4'd0;
    end else begin
      if ((state_q == StHold) && out_ready) begin
        state_d = StIdle;
      end
      if (accept) begin
        signed_d = cur_signed;
        if (!cont || last_idx) begin
          state_d   = StHold;
          acc_d     = '0;
          cnt_d     = 4'd0;
          value_d   = (err_new.err_long || err_new.err_ovf) ? '0 : ext_val;
          res_cnt_d = cnt_new;
          err_d     = err_new;
        end else begin
          state_d = StAccum;
          acc_d   = acc_new;
          cnt_d   = cnt_new;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= 4'd0;
      signed_q  <= 1'b0;
      value_q   <= '0;
      res_cnt_q <= 4'd0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      value_q   <= value_d;
      res_cnt_q <= res_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule
